// File: rtl/exe_pkg.sv
// exe_pkg: shared widths and flag positions for the EXE/MEM pipeline register.
package exe_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 4;
    localparam int CNT_W_DEF  = 16;
    localparam int FLAG_N     = 3;
    localparam int FLAG_Z     = 2;
    localparam int FLAG_C     = 1;
    localparam int FLAG_V     = 0;
endpackage

// File: rtl/status_reg.sv
// status_reg: architectural {N,Z,C,V} flags, updated only when enabled.
module status_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);
    logic [3:0] status_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            status_q <= '0;
        else if (en_i)
            status_q <= d_i;
    end
    assign q_o = status_q;
endmodule

// File: rtl/exe_mem_stage.sv
// exe_mem_stage: EXE->MEM pipeline register with stall, flush, flag register
// and a retired-instruction counter.
module exe_mem_stage
    import exe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic [DATA_W-1:0] alu_res_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic [REG_W-1:0]  dest_in,
    input  logic              s_in,
    input  logic [3:0]        status_bits_in,
    output logic              out_valid,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic [DATA_W-1:0] alu_res,
    output logic [DATA_W-1:0] val_rm,
    output logic [REG_W-1:0]  dest,
    output logic [3:0]        status,
    output logic [CNT_W-1:0]  retired
);
    logic              load;
    logic              valid_q, valid_d, wb_q, wb_d, mr_q, mr_d, mw_q, mw_d;
    logic [DATA_W-1:0] alu_q, alu_d, rm_q, rm_d;
    logic [REG_W-1:0]  dest_q, dest_d;
    logic [CNT_W-1:0]  ret_q, ret_d;

    assign load = !freeze && !flush && in_valid;

    // Bubbles clear the control bits but keep the data registers as they were.
    always_comb begin
        valid_d = freeze ? valid_q : load;
        wb_d    = freeze ? wb_q    : load && wb_en_in;
        mr_d    = freeze ? mr_q    : load && mem_r_en_in;
        mw_d    = freeze ? mw_q    : load && mem_w_en_in;
        alu_d   = load ? alu_res_in : alu_q;
        rm_d    = load ? val_rm_in  : rm_q;
        dest_d  = load ? dest_in    : dest_q;
        ret_d   = load ? ret_q + 1'b1 : ret_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            wb_q    <= 1'b0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            alu_q   <= '0;
            rm_q    <= '0;
            dest_q  <= '0;
            ret_q   <= '0;
        end else begin
            valid_q <= valid_d;
            wb_q    <= wb_d;
            mr_q    <= mr_d;
            mw_q    <= mw_d;
            alu_q   <= alu_d;
            rm_q    <= rm_d;
            dest_q  <= dest_d;
            ret_q   <= ret_d;
        end
    end

    status_reg u_status (
        .clk  (clk),
        .rst  (rst),
        .en_i (load && s_in),
        .d_i  (status_bits_in),
        .q_o  (status)
    );

    assign out_valid = valid_q;
    assign wb_en     = wb_q && valid_q;
    assign mem_r_en  = mr_q && valid_q;
    assign mem_w_en  = mw_q && valid_q;
    assign alu_res   = alu_q;
    assign val_rm    = rm_q;
    assign dest      = dest_q;
    assign retired   = ret_q;
endmodule

// File: tb/tb_exe_mem_stage.sv
// tb_exe_mem_stage: directed stimulus with a per-cycle expected-state scoreboard.
module tb_exe_mem_stage;
    import exe_pkg::*;

    typedef struct packed {
        logic        valid, wb, mr, mw;
        logic [31:0] alu, rm;
        logic [3:0]  dest, status;
        logic [15:0] retired;
    } exp_t;

    logic        clk = 0, rst = 0, freeze = 0, flush = 0, in_valid = 0;
    logic        wb_en_in = 0, mem_r_en_in = 0, mem_w_en_in = 0, s_in = 0;
    logic [31:0] alu_res_in = 0, val_rm_in = 0;
    logic [3:0]  dest_in = 0, status_bits_in = 0;
    logic        out_valid, wb_en, mem_r_en, mem_w_en;
    logic [31:0] alu_res, val_rm;
    logic [3:0]  dest, status;
    logic [15:0] retired;

    int   checks = 0, fails = 0;
    exp_t m = '0;
    exp_t q[$];

    exe_mem_stage dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .in_valid(in_valid),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .alu_res_in(alu_res_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
        .s_in(s_in), .status_bits_in(status_bits_in),
        .out_valid(out_valid), .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .alu_res(alu_res), .val_rm(val_rm), .dest(dest), .status(status), .retired(retired)
    );

    always #5 clk = ~clk;

    // Monitor: one expected record per clock edge, compared half a cycle later.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e, a;
            e = q.pop_front();
            a = '{out_valid, wb_en, mem_r_en, mem_w_en, alu_res, val_rm, dest, status, retired};
            checks++;
            if (a !== e) begin
                fails++;
                $display("FAIL scoreboard t=%0t got v%b wb%b r%b w%b alu=%h rm=%h d=%h st=%b ret=%h want v%b wb%b r%b w%b alu=%h rm=%h d=%h st=%b ret=%h",
                    $time, a.valid, a.wb, a.mr, a.mw, a.alu, a.rm, a.dest, a.status, a.retired,
                    e.valid, e.wb, e.mr, e.mw, e.alu, e.rm, e.dest, e.status, e.retired);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic step(input logic fr, fl, iv, wb, mr, mw, input logic [31:0] alu, rm,
                        input logic [3:0] dst, input logic s, input logic [3:0] sb);
        freeze = fr; flush = fl; in_valid = iv; wb_en_in = wb; mem_r_en_in = mr;
        mem_w_en_in = mw; alu_res_in = alu; val_rm_in = rm; dest_in = dst;
        s_in = s; status_bits_in = sb;
        if (!fr) begin
            logic ld;
            ld = !fl && iv;
            if (ld) begin
                m.alu = alu; m.rm = rm; m.dest = dst; m.retired = m.retired + 1'b1;
                if (s) m.status = sb;
            end
            m.valid = ld; m.wb = ld && wb; m.mr = ld && mr; m.mw = ld && mw;
        end
        @(posedge clk);
        q.push_back(m);
        @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_valid"}, {28'b0, out_valid, wb_en, mem_r_en, mem_w_en}, 0);
        chk({name, "_alu"}, alu_res, 0);
        chk({name, "_rm"}, val_rm, 0);
        chk({name, "_dest_st"}, {24'b0, dest, status}, 0);
        chk({name, "_ret"}, {16'b0, retired}, 0);
    endtask

    initial begin
        #12;
        check_zero("reset");
        @(negedge clk) rst = 1;
        // Basic accept
        step(0,0,1,1,0,0,32'h0000_00FF,32'h11,4'd5,0,4'h0);
        chk("acc_alu", alu_res, 32'hFF);
        chk("acc_dest", {28'b0, dest}, 5);
        chk("acc_wb_valid", {30'b0, wb_en, out_valid}, 3);
        chk("acc_ret", {16'b0, retired}, 1);
        // Flag update then non-updating instruction
        step(0,0,1,0,0,0,32'h1,32'h2,4'd1,1,4'b0110);
        chk("st_set", {28'b0, status}, 4'b0110);
        step(0,0,1,0,0,0,32'h3,32'h4,4'd2,0,4'b1001);
        chk("st_hold", {28'b0, status}, 4'b0110);
        chk("st_z_flag", {31'b0, status[FLAG_Z]}, 1);
        // Simultaneous read and write enables
        step(0,0,1,0,1,1,32'hDEAD_BEEF,32'hCAFE_F00D,4'd9,0,4'h0);
        chk("rw_both", {30'b0, mem_r_en, mem_w_en}, 3);
        // Freeze with flush and changing inputs
        for (int i = 0; i < 3; i++)
            step(1,1,1,1,0,1,32'h100 + i,32'h200 + i,4'(i),1,4'(i + 8));
        chk("frz_ret", {16'b0, retired}, 4);
        chk("frz_alu", alu_res, 32'hDEAD_BEEF);
        step(0,0,1,1,0,0,32'h5555_AAAA,32'h7,4'd3,1,4'b1010);
        chk("frz_release", alu_res, 32'h5555_AAAA);
        // Flush beats a valid store
        step(0,1,1,0,0,1,32'h9,32'h9,4'd7,1,4'b0001);
        chk("flush_vw", {30'b0, out_valid, mem_w_en}, 0);
        chk("flush_st", {28'b0, status}, 4'b1010);
        chk("flush_ret", {16'b0, retired}, 5);
        // Bubble with enables set on the input
        step(0,0,0,1,1,1,32'h8,32'h8,4'd8,1,4'b0011);
        chk("bubble_en", {29'b0, wb_en, mem_r_en, mem_w_en}, 0);
        // Asynchronous reset mid-cycle with live outputs
        step(0,0,1,1,1,0,32'hF0F0_F0F0,32'h1,4'd15,1,4'b1111);
        chk("pre_rst_st", {27'b0, out_valid, status}, 5'h1F);
        freeze = 1;
        @(posedge clk);
        #2 rst = 0;
        m = '0;
        #1 check_zero("async_rst");
        // Release while frozen, then first load
        @(negedge clk) rst = 1;
        step(1,0,1,1,0,0,32'h44,32'h44,4'd4,1,4'b0100);
        step(0,0,1,1,0,0,32'h45,32'h46,4'd6,1,4'b1100);
        chk("post_rst_ret", {16'b0, retired}, 1);
        // Counter wrap: fill to all ones, then one more
        for (int i = 1; i < 65535; i++)
            step(0,0,1,0,0,0,32'(i),32'h0,4'd0,0,4'h0);
        chk("ret_full", {16'b0, retired}, 32'hFFFF);
        step(0,0,1,0,0,0,32'h1234,32'h0,4'd0,0,4'h0);
        chk("ret_wrap", {16'b0, retired}, 0);
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain left %0d want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
